// File: rtl/sram_arbiter.sv
// Two-port (CPU / DMA) arbiter for an asynchronous 16-bit SRAM with a fixed four-state access cycle.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the CPU has fixed priority.
module sram_arbiter (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic [15:0] dma_rdata,
    output logic        dma_ack,
    output logic [15:0] ADDR,
    output logic [15:0] Data_to_SRAM,
    input  logic [15:0] Data_from_SRAM,
    output logic        OE,
    output logic        WE,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

    state_t state;
    logic   sel_dma;
    logic   cur_we;
    logic   grant_dma;
    logic   grant_any;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_dma;

    always_comb begin
        grant_any = cpu_req | dma_req;
        grant_dma = dma_req && (!cpu_req || !last_dma);
    end
`else
    always_comb begin
        grant_any = cpu_req | dma_req;
        grant_dma = dma_req && !cpu_req;
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            sel_dma      <= 1'b0;
            cur_we       <= 1'b0;
            OE           <= 1'b1;
            WE           <= 1'b1;
            cpu_ack      <= 1'b0;
            dma_ack      <= 1'b0;
            busy         <= 1'b0;
            ADDR         <= '0;
            Data_to_SRAM <= '0;
            cpu_rdata    <= '0;
            dma_rdata    <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_dma     <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state        <= ACC1;
                        busy         <= 1'b1;
                        sel_dma      <= grant_dma;
                        cur_we       <= grant_dma ? dma_we : cpu_we;
                        ADDR         <= grant_dma ? dma_addr : cpu_addr;
                        Data_to_SRAM <= grant_dma ? dma_wdata : cpu_wdata;
                        // Strobes are registered, so they are set here to be valid during ACC1
                        OE           <= grant_dma ? dma_we : cpu_we;
                        WE           <= grant_dma ? ~dma_we : ~cpu_we;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                        last_dma     <= grant_dma;
`endif
                    end
                end
                ACC1: state <= ACC2;
                ACC2: begin
                    state <= DONE;
                    OE    <= 1'b1;
                    WE    <= 1'b1;
                    if (sel_dma) dma_ack <= 1'b1;
                    else         cpu_ack <= 1'b1;
                    if (!cur_we) begin
                        if (sel_dma) dma_rdata <= Data_from_SRAM;
                        else         cpu_rdata <= Data_from_SRAM;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model (grant, two access cycles, ack, idle).
module tb_sram_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] dma_addr = '0, dma_wdata = '0;
    logic [15:0] dma_rdata;
    logic        dma_ack;
    logic [15:0] ADDR, Data_to_SRAM;
    logic [15:0] Data_from_SRAM = '0;
    logic        OE, WE, busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // reference model: a transaction is "phase" 1..3 cycles after its grant
    bit          m_active = 0;
    int          m_phase  = 0;
    bit          m_dma = 0, m_we = 0;
    logic [15:0] m_addr = '0, m_dts = '0, m_cpu_rd = '0, m_dma_rd = '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    bit          m_last_dma = 1;
`endif

    // observation bookkeeping
    bit prev_busy = 0;
    int rise_cyc  = 0;
    int oe_low_cnt = 0, we_low_cnt = 0, cpu_ack_cnt = 0, dma_ack_cnt = 0;
    int ack_who[$];
    int ack_when[$];

    sram_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
        .OE(OE), .WE(WE), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit win;
        if (Reset) begin
            m_active = 0; m_phase = 0;
            m_addr = '0; m_dts = '0; m_cpu_rd = '0; m_dma_rd = '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            m_last_dma = 1;
`endif
        end else if (!m_active) begin
            if (cpu_req || dma_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                if (cpu_req && dma_req) win = !m_last_dma;
                else                    win = dma_req;
                m_last_dma = win;
`else
                win = !cpu_req;
`endif
                m_active = 1; m_phase = 1; m_dma = win;
                m_we   = win ? dma_we : cpu_we;
                m_addr = win ? dma_addr : cpu_addr;
                m_dts  = win ? dma_wdata : cpu_wdata;
            end
        end else begin
            if (m_phase == 2 && !m_we) begin
                if (m_dma) m_dma_rd = Data_from_SRAM;
                else       m_cpu_rd = Data_from_SRAM;
            end
            if (m_phase == 3) begin m_active = 0; m_phase = 0; end
            else m_phase++;
        end
    endtask

    task automatic check_outputs();
        bit acc;
        acc = m_active && (m_phase < 3);
        chk("busy",      busy,    m_active);
        chk("OE",        OE,      !(acc && !m_we));
        chk("WE",        WE,      !(acc && m_we));
        chk("cpu_ack",   cpu_ack, m_active && m_phase == 3 && !m_dma);
        chk("dma_ack",   dma_ack, m_active && m_phase == 3 && m_dma);
        chk("ADDR",      ADDR,         m_addr);
        chk("Data_to_SRAM", Data_to_SRAM, m_dts);
        chk("cpu_rdata", cpu_rdata, m_cpu_rd);
        chk("dma_rdata", dma_rdata, m_dma_rd);
        chk("oe_we_excl", OE | WE, 1);
        chk("ack_onehot", cpu_ack & dma_ack, 0);
        if (busy && !prev_busy) rise_cyc = cyc;
        if (cpu_ack || dma_ack) chk("ack_latency", cyc - rise_cyc + 1, 3);
        prev_busy = busy;
        if (!OE) oe_low_cnt++;
        if (!WE) we_low_cnt++;
        if (cpu_ack) begin cpu_ack_cnt++; ack_who.push_back(0); ack_when.push_back(cyc); end
        if (dma_ack) begin dma_ack_cnt++; ack_who.push_back(1); ack_when.push_back(cyc); end
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        cyc++;
        @(negedge Clk);
        check_outputs();
    endtask

    task automatic clear_obs();
        oe_low_cnt = 0; we_low_cnt = 0; cpu_ack_cnt = 0; dma_ack_cnt = 0;
        ack_who.delete(); ack_when.delete();
    endtask

    initial begin
        @(negedge Clk);
        // reset
        Reset = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        chk("rst_ADDR", ADDR, 16'h0000);
        chk("rst_OE_WE", {OE, WE}, 2'b11);

        // CPU write 0x1234 -> 0x3000
        clear_obs();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h3000; cpu_wdata = 16'h1234;
        for (int i = 0; i < 8 && cpu_ack_cnt == 0; i++) tick();
        cpu_req = 0;
        chk("wr_ack_seen", cpu_ack_cnt, 1);
        chk("wr_we_low_cycles", we_low_cnt, 2);
        chk("wr_oe_low_cycles", oe_low_cnt, 0);
        chk("wr_ADDR", ADDR, 16'h3000);
        chk("wr_data", Data_to_SRAM, 16'h1234);
        tick();

        // DMA read of 0x0040 returning 0xBEEF
        clear_obs();
        dma_req = 1; dma_we = 0; dma_addr = 16'h0040; Data_from_SRAM = 16'hBEEF;
        for (int i = 0; i < 8 && dma_ack_cnt == 0; i++) tick();
        dma_req = 0;
        chk("rd_ack_seen", dma_ack_cnt, 1);
        chk("rd_oe_low_cycles", oe_low_cnt, 2);
        chk("rd_dma_rdata", dma_rdata, 16'hBEEF);
        chk("rd_cpu_rdata_kept", cpu_rdata, 16'h0000);
        tick();

        // both requesters held high
        clear_obs();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1111;
        dma_req = 1; dma_we = 0; dma_addr = 16'h2222;
        for (int i = 0; i < 16; i++) begin
            Data_from_SRAM = 16'(i * 16'h0101);
            tick();
        end
        cpu_req = 0; dma_req = 0;
        chk("both_ack_count", ack_who.size(), 4);
        for (int i = 0; i < 4 && i < ack_who.size(); i++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            chk("both_grant_order", ack_who[i], i % 2);
`else
            chk("both_grant_order", ack_who[i], 0);
`endif
            if (i > 0) chk("both_ack_spacing", ack_when[i] - ack_when[i-1], 4);
        end
        tick(); tick();

        // reset during ACC2 of a CPU read
        Reset = 1; tick(); Reset = 0;
        clear_obs();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0ABC; Data_from_SRAM = 16'hDEAD;
        tick(); tick();
        chk("abort_in_acc2_oe", OE, 0);
        Reset = 1; cpu_req = 0;
        tick();
        Reset = 0;
        chk("abort_OE_WE", {OE, WE}, 2'b11);
        chk("abort_busy", busy, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("abort_no_ack", cpu_ack_cnt + dma_ack_cnt, 0);
        chk("abort_rdata", cpu_rdata, 16'h0000);

        // inputs change after grant
        clear_obs();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000; Data_from_SRAM = 16'h7777;
        tick();
        cpu_addr = 16'h5555; cpu_req = 0;
        chk("chg_ADDR_acc1", ADDR, 16'h3000);
        for (int i = 0; i < 6; i++) tick();
        chk("chg_ack_count", cpu_ack_cnt, 1);
        chk("chg_ADDR_final", ADDR, 16'h3000);
        chk("chg_rdata", cpu_rdata, 16'h7777);

        // random mixed traffic
        for (int i = 0; i < 1000; i++) begin
            if (!cpu_req && $urandom_range(3) == 0) cpu_req = 1;
            if (!dma_req && $urandom_range(3) == 0) dma_req = 1;
            cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
            dma_we = 1'($urandom); dma_addr = 16'($urandom); dma_wdata = 16'($urandom);
            Data_from_SRAM = 16'($urandom);
            tick();
            if (cpu_ack && $urandom_range(1) == 0) cpu_req = 0;
            if (dma_ack && $urandom_range(1) == 0) dma_req = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
